// File: rtl/memory_unit.sv
// Word-addressed memory with a fixed request-to-response latency and a
// shared tri-state data bus toward the cpu.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module memory_unit #(
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  readM,
   input  logic                  writeM,
   input  logic [15:0]           address,
   inout  wire  [`WORD_SIZE-1:0] data,
   output logic                  inputReady,
   output logic                  ackOutput
);

   localparam int unsigned WORDS = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                state;
   state_t                next_state;
   logic [3:0]            count;
   logic [3:0]            next_count;
   logic                  accept;

   logic [DEPTH_LOG2-1:0] lat_addr;
   logic                  lat_read;
   logic [`WORD_SIZE-1:0] lat_data;

   logic [`WORD_SIZE-1:0] mem [WORDS];
   logic                  mem_we;
   logic [DEPTH_LOG2-1:0] wr_addr;
   logic [`WORD_SIZE-1:0] wr_data;
   logic [`WORD_SIZE-1:0] rd_word;
   logic                  unused_addr;

   // Upper address bits are don't-care: the store wraps on the low bits.
   assign unused_addr = ^address;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         count    <= '0;
         lat_addr <= '0;
         lat_read <= 1'b0;
         lat_data <= '0;
      end else begin
         state <= next_state;
         count <= next_count;
         if (accept) begin
            lat_addr <= address[DEPTH_LOG2-1:0];
            lat_read <= readM;
            lat_data <= data;
         end
      end
   end

   always_comb begin
      next_state = state;
      next_count = count;
      accept     = 1'b0;
      inputReady = 1'b0;
      ackOutput  = 1'b0;
      unique case (state)
         IDLE: begin
            if (readM || writeM) begin
               accept     = 1'b1;
               next_count = 4'(LATENCY - 1);
               next_state = (LATENCY == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            next_count = count - 4'd1;
            if (count == 4'd1) begin
               next_state = RESP;
            end
         end
         RESP: begin
            next_state = IDLE;
            inputReady = lat_read;
            ackOutput  = ~lat_read;
         end
         default: next_state = IDLE;
      endcase
   end

   // With LATENCY=1 the edge entering RESP is the acceptance edge itself,
   // so the write takes the live bus values instead of the latched copies.
   always_comb begin
      mem_we  = 1'b0;
      wr_addr = lat_addr;
      wr_data = lat_data;
      if ((state == IDLE) && (LATENCY == 1)) begin
         mem_we  = writeM && !readM;
         wr_addr = address[DEPTH_LOG2-1:0];
         wr_data = data;
      end else if ((state == BUSY) && (count == 4'd1)) begin
         mem_we = ~lat_read;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && mem_we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_word = mem[lat_addr];
   assign data    = inputReady ? rd_word : 'z;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: directed scenarios plus randomized
// accesses against an array model of the store.
module tb_memory_unit;

   localparam int unsigned LAT   = 2;
   localparam int unsigned DL    = 8;
   localparam int unsigned WORDS = 1 << DL;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;

   // Main instance. The bench drives a known value on the bus in every cycle
   // it is not expecting read data, so any stray DUT drive corrupts it.
   logic        rd, wr, drv;
   logic [15:0] addr, bval;
   wire  [15:0] data;
   logic        inputReady, ackOutput;
   assign data = drv ? bval : 'z;

   memory_unit #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut (
      .clk(clk), .reset_n(reset_n), .readM(rd), .writeM(wr), .address(addr),
      .data(data), .inputReady(inputReady), .ackOutput(ackOutput));

   // Second instance with the minimum latency.
   logic        rd1, wr1, drv1;
   logic [15:0] addr1, bval1;
   wire  [15:0] data1;
   logic        ir1, ack1;
   assign data1 = drv1 ? bval1 : 'z;

   memory_unit #(.LATENCY(1), .DEPTH_LOG2(DL)) dut1 (
      .clk(clk), .reset_n(reset_n), .readM(rd1), .writeM(wr1), .address(addr1),
      .data(data1), .inputReady(ir1), .ackOutput(ack1));

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [15:0] ref_mem [WORDS];
   logic        known   [WORDS];
   int unsigned kq[$];

   function automatic void model_write(input logic [15:0] a, input logic [15:0] d);
      int unsigned idx;
      idx = int'(a) % WORDS;
      ref_mem[idx] = d;
      if (!known[idx]) begin
         known[idx] = 1'b1;
         kq.push_back(idx);
      end
   endfunction

   // One access on the main instance. The request is driven just after launch
   // edge T; a response is expected in the cycle after edge T+LATENCY.
   // obs = {ir seen, ack seen, first response edge, response cycles, bus clean}
   task automatic xact(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic scramble,
                       output logic [10:0] obs, output logic [15:0] rdata);
      logic        irs, acks, bok;
      int unsigned lat, width;
      irs = 1'b0; acks = 1'b0; bok = 1'b1; lat = 0; width = 0; rdata = '0;
      @(posedge clk); #1;
      rd = r; wr = w; addr = a; bval = w ? d : 16'h0000; drv = 1'b1;
      for (int unsigned n = 1; n <= LAT + 2; n++) begin
         @(posedge clk); #1;
         if (n == 1 && scramble) begin
            addr = ~a;
            bval = ~bval;
         end
         drv = !(r && n == LAT);
         @(negedge clk);
         if (inputReady || ackOutput) begin
            if (width == 0) begin
               lat   = n;
               rdata = data;
            end
            width++;
            irs  |= inputReady;
            acks |= ackOutput;
            rd = 1'b0;
            wr = 1'b0;
         end
         if (drv && data !== bval) bok = 1'b0;
      end
      rd = 1'b0; wr = 1'b0; drv = 1'b1; bval = 16'h0000;
      obs = {irs, acks, 4'(lat), 4'(width), bok};
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      rd = 1'b0; wr = 1'b0; addr = '0; bval = '0; drv = 1'b1;
      rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; bval1 = '0; drv1 = 1'b1;
      for (int unsigned i = 0; i < WORDS; i++) known[i] = 1'b0;
      #3;
      total++;
      if ({inputReady, ackOutput, data} !== {2'b00, 16'h0000}) begin
         bad++;
         $display("FAIL reset_main: got ir=%b ack=%b bus=%h want 0 0 0000", inputReady, ackOutput, data);
      end
      total++;
      if ({ir1, ack1, data1} !== {2'b00, 16'h0000}) begin
         bad++;
         $display("FAIL reset_lat1: got ir=%b ack=%b bus=%h want 0 0 0000", ir1, ack1, data1);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      total++;
      if ({inputReady, ackOutput} !== 2'b00) begin
         bad++;
         $display("FAIL reset_release_idle: got ir=%b ack=%b want 0 0", inputReady, ackOutput);
      end
   endtask

   task automatic test_directed();
      logic [10:0] obs;
      logic [15:0] rdat;
      xact(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, obs, rdat);
      model_write(16'h0010, 16'hBEEF);
      total++;
      if (obs !== {1'b0, 1'b1, 4'(LAT), 4'd1, 1'b1}) begin
         bad++;
         $display("FAIL write_beef_timing: got %b want %b", obs, {1'b0, 1'b1, 4'(LAT), 4'd1, 1'b1});
      end
      xact(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, obs, rdat);
      total++;
      if (obs !== {1'b1, 1'b0, 4'(LAT), 4'd1, 1'b1}) begin
         bad++;
         $display("FAIL read_beef_timing: got %b want %b", obs, {1'b1, 1'b0, 4'(LAT), 4'd1, 1'b1});
      end
      total++;
      if (rdat !== 16'hBEEF) begin
         bad++;
         $display("FAIL read_beef_data: got %h want beef", rdat);
      end
   endtask

   task automatic test_both();
      logic [10:0] obs;
      logic [15:0] rdat;
      xact(1'b0, 1'b1, 16'h0005, 16'h1234, 1'b0, obs, rdat);
      model_write(16'h0005, 16'h1234);
      xact(1'b1, 1'b1, 16'h0005, 16'hFFFF, 1'b0, obs, rdat);
      total++;
      if ({obs, rdat} !== {1'b1, 1'b0, 4'(LAT), 4'd1, 1'b1, 16'h1234}) begin
         bad++;
         $display("FAIL read_write_both: got obs=%b data=%h want obs=%b data=1234", obs, rdat, {1'b1, 1'b0, 4'(LAT), 4'd1, 1'b1});
      end
      xact(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, obs, rdat);
      total++;
      if (rdat !== 16'h1234) begin
         bad++;
         $display("FAIL both_write_discarded: got %h want 1234", rdat);
      end
   endtask

   task automatic test_wrap();
      logic [10:0] obs;
      logic [15:0] rdat;
      xact(1'b0, 1'b1, 16'h0103, 16'h00AA, 1'b0, obs, rdat);
      model_write(16'h0103, 16'h00AA);
      xact(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, obs, rdat);
      total++;
      if (rdat !== ref_mem[3]) begin
         bad++;
         $display("FAIL wrap_read_0003: got %h want %h", rdat, ref_mem[3]);
      end
      xact(1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0, obs, rdat);
      total++;
      if (rdat !== 16'h00AA) begin
         bad++;
         $display("FAIL wrap_read_ff03: got %h want 00aa", rdat);
      end
   endtask

   task automatic test_latch();
      logic [10:0] obs;
      logic [15:0] rdat;
      xact(1'b0, 1'b1, 16'h0040, 16'h0C0C, 1'b1, obs, rdat);
      model_write(16'h0040, 16'h0C0C);
      xact(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, obs, rdat);
      total++;
      if ({obs, rdat} !== {1'b1, 1'b0, 4'(LAT), 4'd1, 1'b1, 16'h0C0C}) begin
         bad++;
         $display("FAIL latched_values: got obs=%b data=%h want data=0c0c", obs, rdat);
      end
   endtask

   task automatic test_reset_busy();
      logic [10:0] obs;
      logic [15:0] rdat;
      xact(1'b0, 1'b1, 16'h0020, 16'h7777, 1'b0, obs, rdat);
      model_write(16'h0020, 16'h7777);
      @(posedge clk); #1;
      wr = 1'b1; addr = 16'h0020; bval = 16'h5555; drv = 1'b1;
      @(posedge clk); #1;
      wr = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({inputReady, ackOutput, data} !== {2'b00, 16'h5555}) begin
         bad++;
         $display("FAIL reset_in_busy: got ir=%b ack=%b bus=%h want 0 0 5555", inputReady, ackOutput, data);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      total++;
      if ({inputReady, ackOutput} !== 2'b00) begin
         bad++;
         $display("FAIL aborted_write_ack: got ir=%b ack=%b want 0 0", inputReady, ackOutput);
      end
      xact(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, obs, rdat);
      total++;
      if ({obs, rdat} !== {1'b1, 1'b0, 4'(LAT), 4'd1, 1'b1, 16'h7777}) begin
         bad++;
         $display("FAIL aborted_write_storage: got obs=%b data=%h want data=7777", obs, rdat);
      end

      xact(1'b0, 1'b1, 16'h0030, 16'h5A5A, 1'b0, obs, rdat);
      model_write(16'h0030, 16'h5A5A);
      @(posedge clk); #1;
      rd = 1'b1; addr = 16'h0030; bval = 16'h0000; drv = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      drv = 1'b0;
      @(negedge clk);
      total++;
      if ({inputReady, data} !== {1'b1, 16'h5A5A}) begin
         bad++;
         $display("FAIL resp_before_reset: got ir=%b bus=%h want 1 5a5a", inputReady, data);
      end
      #1;
      rd = 1'b0; drv = 1'b1; reset_n = 1'b0;
      #1;
      total++;
      if ({inputReady, ackOutput, data} !== {2'b00, 16'h0000}) begin
         bad++;
         $display("FAIL reset_in_resp: got ir=%b ack=%b bus=%h want 0 0 0000", inputReady, ackOutput, data);
      end
      #1 reset_n = 1'b1;
      xact(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, obs, rdat);
      total++;
      if (rdat !== 16'h5A5A) begin
         bad++;
         $display("FAIL storage_kept_over_reset: got %h want 5a5a", rdat);
      end
   endtask

   // A held read is re-accepted on the first IDLE edge, so responses repeat
   // every LATENCY+1 edges.
   task automatic test_back_to_back();
      logic [10:0] obs;
      logic [15:0] rdat;
      logic [15:0] v;
      logic        e;
      v = 16'(($urandom_range(1, 16'hFFFE)));
      xact(1'b0, 1'b1, 16'h0077, v, 1'b0, obs, rdat);
      model_write(16'h0077, v);
      @(posedge clk); #1;
      rd = 1'b1; addr = 16'h0077; bval = 16'h0000; drv = 1'b1;
      for (int unsigned n = 1; n <= 8; n++) begin
         e = (n % (LAT + 1) == LAT);
         @(posedge clk); #1;
         drv = !e;
         @(negedge clk);
         total++;
         if ({inputReady, ackOutput, data} !== {e, 1'b0, (e ? v : 16'h0000)}) begin
            bad++;
            $display("FAIL held_read_lat2 n=%0d: got ir=%b ack=%b bus=%h want %b 0 %h", n, inputReady, ackOutput, data, e, (e ? v : 16'h0000));
         end
         if (n == 8) rd = 1'b0;
      end
      drv = 1'b1;
   endtask

   task automatic test_back_to_back_lat1();
      logic [15:0] v;
      logic        e;
      v = 16'h9A9A;
      @(posedge clk); #1;
      wr1 = 1'b1; addr1 = 16'h0155; bval1 = v; drv1 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({ir1, ack1} !== 2'b01) begin
         bad++;
         $display("FAIL lat1_write_ack: got ir=%b ack=%b want 0 1", ir1, ack1);
      end
      wr1 = 1'b0;
      @(negedge clk);
      total++;
      if ({ir1, ack1} !== 2'b00) begin
         bad++;
         $display("FAIL lat1_write_single: got ir=%b ack=%b want 0 0", ir1, ack1);
      end
      bval1 = 16'h0000;
      @(posedge clk); #1;
      rd1 = 1'b1; addr1 = 16'h0055;
      for (int unsigned n = 1; n <= 6; n++) begin
         e = (n % 2 == 1);
         @(posedge clk); #1;
         drv1 = !e;
         @(negedge clk);
         total++;
         if ({ir1, ack1, data1} !== {e, 1'b0, (e ? v : 16'h0000)}) begin
            bad++;
            $display("FAIL held_read_lat1 n=%0d: got ir=%b ack=%b bus=%h want %b 0 %h", n, ir1, ack1, data1, e, (e ? v : 16'h0000));
         end
         if (n == 5) rd1 = 1'b0;
      end
      drv1 = 1'b1;
   endtask

   task automatic test_random();
      logic [10:0] obs, exp_obs;
      logic [15:0] rdat, a, d, exp_d;
      logic        r, w;
      int unsigned k, idx;
      for (int unsigned it = 0; it < 40; it++) begin
         k = $urandom_range(0, 3);
         d = 16'($urandom);
         if (kq.size() == 0 || k == 0) begin
            r = 1'b0; w = 1'b1;
            a = 16'($urandom);
         end else begin
            r = 1'b1; w = (k == 1);
            idx = kq[$urandom_range(0, kq.size() - 1)];
            a = 16'(($urandom_range(0, 255) << DL) + idx);
         end
         exp_d = ref_mem[int'(a) % WORDS];
         xact(r, w, a, d, 1'b0, obs, rdat);
         if (!r) model_write(a, d);
         exp_obs = {r, !r, 4'(LAT), 4'd1, 1'b1};
         total++;
         if (obs !== exp_obs) begin
            bad++;
            $display("FAIL rand_timing #%0d addr=%h: got %b want %b", it, a, obs, exp_obs);
         end
         if (r) begin
            total++;
            if (rdat !== exp_d) begin
               bad++;
               $display("FAIL rand_read #%0d addr=%h: got %h want %h", it, a, rdat, exp_d);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_both();
      test_wrap();
      test_latch();
      test_reset_busy();
      test_back_to_back();
      test_back_to_back_lat1();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
